parc_core_rob_ctrl: RTL and testbench
=====================================

# parc_core_rob_ctrl

Reorder-buffer control block for the pv2ooo core. It allocates ROB slots in program order at decode and records each slot's destination register. It tracks which slots the writeback stage has filled and retires filled slots in order, at most one per cycle. It drives the datapath's ROB fill/commit controls and answers decode-stage source lookups, so the bypass muxes can select ROB data or the control unit can stall.

## Interface
Parameters:
- ENTRIES, 16, number of ROB slots (power of two)
- SLOT_BITS, 4, log2(ENTRIES)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately
- alloc_val  in  1  decode requests a slot this cycle
- alloc_rdy  out  1  a free slot exists
- alloc_wen  in  1  allocating instruction writes a register
- alloc_waddr  in  5  destination register of allocating instruction
- alloc_slot  out  SLOT_BITS  slot granted (current tail)
- rob_fill_wen_Whl  in  1  writeback deposits a result this cycle
- rob_fill_slot_Whl  in  SLOT_BITS  slot being filled
- rob_commit_wen_Chl  out  1  regfile write enable for the retiring slot
- rob_commit_slot_Chl  out  SLOT_BITS  retiring slot (current head)
- rob_commit_waddr_Chl  out  5  regfile address for the retiring slot
- src0_addr, src1_addr  in  5  decode source registers
- src0_hit, src1_hit  out  1  an in-flight slot will write this register
- src0_pending, src1_pending  out  1  the youngest such slot is not yet filled
- src0_slot, src1_slot  out  SLOT_BITS  youngest matching slot
- count  out  SLOT_BITS+1  occupied slots

## Operation
- Per-slot state: valid, filled, wen, waddr[4:0]. Pointers: head and tail (SLOT_BITS wide, wrap ENTRIES-1 to 0). Count is 0..ENTRIES.
- Alloc fires when alloc_val & alloc_rdy. At the edge: slot[tail] gets valid=1, filled=0, wen=alloc_wen, waddr=alloc_waddr; tail increments.
- alloc_rdy = (count != ENTRIES). It depends on registered count only. A commit in the same cycle does not free a slot for that cycle's alloc.
- alloc_slot = tail at all times, regardless of alloc_val.
- Fill: if rob_fill_wen_Whl and slot[rob_fill_slot_Whl].valid, set filled=1. A fill to an invalid slot is ignored. A fill to an already filled slot is idempotent.
- Commit happens when slot[head] is valid & filled. The retire is combinational from registered state. At the edge: slot[head].valid=0, head increments, count decrements.
- rob_commit_wen_Chl = retire & wen[head] & (waddr[head] != 0).
- rob_commit_slot_Chl = head and rob_commit_waddr_Chl = waddr[head] at all times.
- A retiring slot with wen=0 (stores, branches) still advances head.
- Alloc and commit in the same cycle leave count unchanged.
- Lookup, per source: among valid slots with wen=1 and waddr == src_addr, select the youngest, i.e. the one nearest tail-1 scanning back toward head.
  - hit = match exists. slot = that slot. pending = !filled[slot].
  - src_addr == 0 never hits.
  - With no hit: slot = 0 and pending = 0.
- Lookup uses registered state only:
  - A same-cycle alloc is not visible.
  - A same-cycle fill still shows pending=1; the datapath covers this case with the W-stage bypass.
  - A slot retiring this cycle still hits with pending=0.

## Timing
- Reset (reset=0), asynchronous: head=tail=0, count=0, all valid/filled=0. Outputs: alloc_rdy=1, alloc_slot=0, rob_commit_wen_Chl=0, rob_commit_slot_Chl=0, rob_commit_waddr_Chl=0, all hit/pending/slot=0, count=0.
- Reset asserted mid-operation discards every in-flight slot. No commit is issued after reset asserts.
- Alloc at edge N: the slot is visible to lookup and count in cycle N+1.
- Fill at edge N: the earliest commit for that slot is asserted during cycle N+1 and takes effect at edge N+1.
- Throughput is 1 alloc, 1 fill and 1 commit per cycle. All three may occur in the same cycle, including at full (commit only) and empty (alloc only).
- A slot allocated at edge N and filled at edge N+1 can retire no earlier than edge N+2.

## Test plan
- Reset then in-order flow:
  - Stimulus: alloc r3, r4, r5 into slots 0,1,2; fill slots 0,1,2 on consecutive cycles.
  - Required: commits slot 0/r3, then 1/r4, then 2/r5 on consecutive cycles; count returns to 0.
- Out-of-order fill:
  - Stimulus: alloc slots 0..2, fill in order 2,1,0.
  - Required: no commit until slot 0 fills; then three back-to-back commits in slot order 0,1,2.
- Full/wrap:
  - Stimulus: 16 allocs without fill.
  - Required: alloc_rdy=0, count=16.
  - Then fill slot 0 with alloc_val held: slot 0 commits; alloc_rdy rises the next cycle; the next alloc_slot=0 with head=1.
- Youngest lookup:
  - Stimulus: alloc r7 (slot 0), r7 (slot 1), fill slot 1; src0_addr=7.
  - Required: hit=1, slot=1, pending=0.
  - Stimulus: src1_addr=0 with r0 writers in flight. Required: hit=0.
- Non-writer and r0 retire:
  - Stimulus: alloc with wen=0, then wen=1/waddr=0; fill both.
  - Required: head advances twice, rob_commit_wen_Chl stays 0.
  - Stimulus: fill an invalid slot. Required: no state change.
- Async reset mid-flight:
  - Stimulus: 5 slots allocated, 2 filled; drive reset=0 between edges.
  - Required: count=0, alloc_rdy=1, commit_wen=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/parc_core_rob_ctrl.sv
// Reorder-buffer control: in-order slot allocation, fill tracking, in-order retire.
// Ports: alloc_* (decode), rob_fill_*_Whl (writeback), rob_commit_*_Chl (commit), src*_ (lookup), count.
module parc_core_rob_ctrl #(
  parameter int ENTRIES   = 16,
  parameter int SLOT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_val,
  output logic                 alloc_rdy,
  input  logic                 alloc_wen,
  input  logic [4:0]           alloc_waddr,
  output logic [SLOT_BITS-1:0] alloc_slot,
  input  logic                 rob_fill_wen_Whl,
  input  logic [SLOT_BITS-1:0] rob_fill_slot_Whl,
  output logic                 rob_commit_wen_Chl,
  output logic [SLOT_BITS-1:0] rob_commit_slot_Chl,
  output logic [4:0]           rob_commit_waddr_Chl,
  input  logic [4:0]           src0_addr,
  input  logic [4:0]           src1_addr,
  output logic                 src0_hit,
  output logic                 src1_hit,
  output logic                 src0_pending,
  output logic                 src1_pending,
  output logic [SLOT_BITS-1:0] src0_slot,
  output logic [SLOT_BITS-1:0] src1_slot,
  output logic [SLOT_BITS:0]   count
);

  localparam logic [SLOT_BITS:0] FULL =
    (SLOT_BITS+1)'(ENTRIES);

  typedef struct packed {
    logic                 hit;
    logic                 pend;
    logic [SLOT_BITS-1:0] slot;
  } look_t;

  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   filled_q;
  logic [ENTRIES-1:0]   wen_q;
  logic [4:0]           waddr_q [ENTRIES];
  logic [SLOT_BITS-1:0] head_q;
  logic [SLOT_BITS-1:0] tail_q;
  logic [SLOT_BITS:0]   count_q;

  logic alloc_fire;
  logic retire;
  logic fill_ok;
  look_t look0;
  look_t look1;

  assign alloc_rdy  = (count_q != FULL);
  assign alloc_fire = alloc_val & alloc_rdy;
  assign alloc_slot = tail_q;
  assign count      = count_q;

  assign retire  = valid_q[head_q] & filled_q[head_q];
  assign fill_ok = rob_fill_wen_Whl
                 & valid_q[rob_fill_slot_Whl];

  assign rob_commit_slot_Chl  = head_q;
  assign rob_commit_waddr_Chl = waddr_q[head_q];
  assign rob_commit_wen_Chl   = retire
                              & wen_q[head_q]
                              & (waddr_q[head_q] != 5'd0);

  // Walk from the oldest position (tail-ENTRIES) to the
  // youngest (tail-1); later matches overwrite, so the
  // youngest writer wins.
  function automatic look_t lookup(
    input logic [4:0] a
  );
    look_t r;
    logic [SLOT_BITS-1:0] idx;
    r = '0;
    for (int k = ENTRIES; k >= 1; k--) begin
      idx = tail_q - SLOT_BITS'(k);
      if ((a != 5'd0) && valid_q[idx] &&
          wen_q[idx] && (waddr_q[idx] == a)) begin
        r.hit  = 1'b1;
        r.slot = idx;
        r.pend = ~filled_q[idx];
      end
    end
    return r;
  endfunction

  always_comb begin
    look0 = lookup(src0_addr);
    look1 = lookup(src1_addr);
  end

  assign src0_hit     = look0.hit;
  assign src0_pending = look0.pend;
  assign src0_slot    = look0.slot;
  assign src1_hit     = look1.hit;
  assign src1_pending = look1.pend;
  assign src1_slot    = look1.slot;

  // Alloc writes last so a fresh slot always starts
  // unfilled; it never collides with the head slot
  // because alloc is blocked at full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      filled_q <= '0;
      wen_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int i = 0; i < ENTRIES; i++)
        waddr_q[i] <= '0;
    end else begin
      if (fill_ok)
        filled_q[rob_fill_slot_Whl] <= 1'b1;
      if (retire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_q[tail_q]  <= 1'b1;
        filled_q[tail_q] <= 1'b0;
        wen_q[tail_q]    <= alloc_wen;
        waddr_q[tail_q]  <= alloc_waddr;
        tail_q           <= tail_q + 1'b1;
      end
      unique case ({alloc_fire, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_parc_core_rob_ctrl.sv
// Bench for parc_core_rob_ctrl: vector table plus
// queue-based reference scoreboard and corner sequences.
module tb_parc_core_rob_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_val;
  logic       alloc_rdy;
  logic       alloc_wen;
  logic [4:0] alloc_waddr;
  logic [3:0] alloc_slot;
  logic       rob_fill_wen_Whl;
  logic [3:0] rob_fill_slot_Whl;
  logic       rob_commit_wen_Chl;
  logic [3:0] rob_commit_slot_Chl;
  logic [4:0] rob_commit_waddr_Chl;
  logic [4:0] src0_addr;
  logic [4:0] src1_addr;
  logic       src0_hit;
  logic       src1_hit;
  logic       src0_pending;
  logic       src1_pending;
  logic [3:0] src0_slot;
  logic [3:0] src1_slot;
  logic [4:0] count;

  parc_core_rob_ctrl #(
    .ENTRIES(16),
    .SLOT_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .alloc_val(alloc_val),
    .alloc_rdy(alloc_rdy),
    .alloc_wen(alloc_wen),
    .alloc_waddr(alloc_waddr),
    .alloc_slot(alloc_slot),
    .rob_fill_wen_Whl(rob_fill_wen_Whl),
    .rob_fill_slot_Whl(rob_fill_slot_Whl),
    .rob_commit_wen_Chl(rob_commit_wen_Chl),
    .rob_commit_slot_Chl(rob_commit_slot_Chl),
    .rob_commit_waddr_Chl(rob_commit_waddr_Chl),
    .src0_addr(src0_addr),
    .src1_addr(src1_addr),
    .src0_hit(src0_hit),
    .src1_hit(src1_hit),
    .src0_pending(src0_pending),
    .src1_pending(src1_pending),
    .src0_slot(src0_slot),
    .src1_slot(src1_slot),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   slot;
    bit   wen;
    int   waddr;
    bit   filled;
  } ent_t;

  typedef struct {
    bit rst;
    bit av;
    int wa;
    bit fv;
    int fs;
    int cnt;
    bit cw;
    int cs;
    int cwa;
  } vec_t;

  ent_t sb[$];
  int   m_head;
  int   m_tail;
  int   m_wa [16];
  int   n_chk;
  int   n_fail;
  vec_t tbl [16];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_head = 0;
    m_tail = 0;
    for (int i = 0; i < 16; i++) m_wa[i] = 0;
  endtask

  task automatic m_look(input int a, output bit h,
                        output int s, output bit p);
    h = 0; s = 0; p = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (a != 0 && sb[i].wen && sb[i].waddr == a) begin
        h = 1;
        s = sb[i].slot;
        p = !sb[i].filled;
        break;
      end
    end
  endtask

  task automatic check_model();
    bit ret;
    bit h;
    int s;
    bit p;
    ret = (sb.size() > 0) && sb[0].filled;
    chk("count", int'(count), sb.size());
    chk("alloc_rdy", int'(alloc_rdy), int'(sb.size() < 16));
    chk("alloc_slot", int'(alloc_slot), m_tail);
    chk("commit_slot", int'(rob_commit_slot_Chl), m_head);
    chk("commit_waddr", int'(rob_commit_waddr_Chl),
        m_wa[m_head]);
    chk("commit_wen", int'(rob_commit_wen_Chl),
        int'(ret && sb[0].wen && sb[0].waddr != 0));
    m_look(int'(src0_addr), h, s, p);
    chk("src0_hit", int'(src0_hit), int'(h));
    chk("src0_slot", int'(src0_slot), s);
    chk("src0_pend", int'(src0_pending), int'(p));
    m_look(int'(src1_addr), h, s, p);
    chk("src1_hit", int'(src1_hit), int'(h));
    chk("src1_slot", int'(src1_slot), s);
    chk("src1_pend", int'(src1_pending), int'(p));
  endtask

  // Edge update: retire decided from pre-edge state,
  // fills only reach already-allocated slots.
  task automatic model_edge();
    bit ret;
    bit af;
    ent_t e;
    ret = (sb.size() > 0) && sb[0].filled;
    af  = alloc_val && (sb.size() < 16);
    if (rob_fill_wen_Whl)
      foreach (sb[i])
        if (sb[i].slot == int'(rob_fill_slot_Whl))
          sb[i].filled = 1;
    if (ret) begin
      void'(sb.pop_front());
      m_head = (m_head + 1) % 16;
    end
    if (af) begin
      e.slot   = m_tail;
      e.wen    = alloc_wen;
      e.waddr  = int'(alloc_waddr);
      e.filled = 0;
      sb.push_back(e);
      m_wa[m_tail] = int'(alloc_waddr);
      m_tail = (m_tail + 1) % 16;
    end
  endtask

  task automatic drive(input bit av, input bit aw,
                       input int wa, input bit fv,
                       input int fs);
    alloc_val         = av;
    alloc_wen         = aw;
    alloc_waddr       = 5'(wa);
    rob_fill_wen_Whl  = fv;
    rob_fill_slot_Whl = 4'(fs);
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_clear();
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic vec_t mk(bit rst, bit av, int wa,
                              bit fv, int fs, int cnt,
                              bit cw, int cs, int cwa);
    vec_t v;
    v.rst = rst; v.av = av; v.wa = wa;
    v.fv = fv; v.fs = fs; v.cnt = cnt;
    v.cw = cw; v.cs = cs; v.cwa = cwa;
    return v;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    src0_addr = 5'd3;
    src1_addr = 5'd6;
    model_clear();

    // in-order flow
    tbl[0]  = mk(1, 1, 3, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 4, 1, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 5, 1, 1, 2, 1, 0, 3);
    tbl[3]  = mk(0, 0, 0, 1, 2, 2, 1, 1, 4);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 1, 2, 5);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);
    // out-of-order fill
    tbl[6]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 2, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 6, 0, 0, 2, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 2, 3, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 3, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 0, 3, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 3, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 2, 1, 1, 2);
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 1, 2, 6);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) apply_reset();
      drive(tbl[i].av, 1, tbl[i].wa,
            tbl[i].fv, tbl[i].fs);
      chk("tbl_count", int'(count), tbl[i].cnt);
      chk("tbl_cwen", int'(rob_commit_wen_Chl),
          int'(tbl[i].cw));
      chk("tbl_cslot", int'(rob_commit_slot_Chl),
          tbl[i].cs);
      if (tbl[i].cw)
        chk("tbl_cwaddr", int'(rob_commit_waddr_Chl),
            tbl[i].cwa);
      step();
    end

    // full and wrap
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, i + 1, 0, 0);
      step();
    end
    drive(1, 1, 20, 1, 0);
    chk("full_rdy", int'(alloc_rdy), 0);
    chk("full_count", int'(count), 16);
    chk("full_cwen0", int'(rob_commit_wen_Chl), 0);
    step();
    drive(1, 1, 20, 0, 0);
    chk("full_cwen1", int'(rob_commit_wen_Chl), 1);
    chk("full_cslot", int'(rob_commit_slot_Chl), 0);
    chk("full_rdy_hold", int'(alloc_rdy), 0);
    step();
    chk("wrap_rdy", int'(alloc_rdy), 1);
    chk("wrap_aslot", int'(alloc_slot), 0);
    chk("wrap_head", int'(rob_commit_slot_Chl), 1);
    chk("wrap_count", int'(count), 15);
    step();
    drive(0, 0, 0, 0, 0);
    chk("refull_count", int'(count), 16);
    chk("refull_rdy", int'(alloc_rdy), 0);
    step();

    // youngest lookup
    apply_reset();
    src0_addr = 5'd7;
    src1_addr = 5'd0;
    drive(1, 1, 7, 0, 0); step();
    drive(1, 1, 7, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 1, 1);
    chk("yl_hit_a", int'(src0_hit), 1);
    chk("yl_slot_a", int'(src0_slot), 1);
    chk("yl_pend_a", int'(src0_pending), 1);
    step();
    drive(0, 0, 0, 0, 0);
    chk("yl_hit", int'(src0_hit), 1);
    chk("yl_slot", int'(src0_slot), 1);
    chk("yl_pend", int'(src0_pending), 0);
    chk("yl_r0_hit", int'(src1_hit), 0);
    step();

    // non-writer and r0 retire, invalid fill
    apply_reset();
    src0_addr = 5'd9;
    src1_addr = 5'd0;
    drive(1, 0, 9, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(0, 0, 0, 1, 0);
    chk("nw_hit", int'(src0_hit), 0);
    step();
    drive(0, 0, 0, 1, 1);
    chk("nw_cwen0", int'(rob_commit_wen_Chl), 0);
    chk("nw_head0", int'(rob_commit_slot_Chl), 0);
    step();
    drive(0, 0, 0, 0, 0);
    chk("nw_cwen1", int'(rob_commit_wen_Chl), 0);
    chk("nw_head1", int'(rob_commit_slot_Chl), 1);
    step();
    drive(0, 0, 0, 1, 5);
    chk("nw_head2", int'(rob_commit_slot_Chl), 2);
    step();
    drive(0, 0, 0, 0, 0);
    chk("inv_count", int'(count), 0);
    chk("inv_head", int'(rob_commit_slot_Chl), 2);
    chk("inv_tail", int'(alloc_slot), 2);
    chk("inv_cwen", int'(rob_commit_wen_Chl), 0);
    step();

    // asynchronous reset mid-flight
    apply_reset();
    src0_addr = 5'd4;
    src1_addr = 5'd2;
    drive(1, 1, 1, 0, 0); step();
    drive(1, 1, 2, 0, 0); step();
    drive(1, 1, 3, 1, 1); step();
    drive(1, 1, 4, 0, 0); step();
    drive(1, 1, 5, 1, 0); step();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_cwen", int'(rob_commit_wen_Chl), 1);
    chk("pre_rst_count", int'(count), 5);
    reset = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_rdy", int'(alloc_rdy), 1);
    chk("arst_cwen", int'(rob_commit_wen_Chl), 0);
    chk("arst_cslot", int'(rob_commit_slot_Chl), 0);
    chk("arst_aslot", int'(alloc_slot), 0);
    chk("arst_hit", int'(src0_hit), 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
